// File: rtl/link_scheduler_pkg.sv
// Shared FSM state encoding and TX window membership helper for the radio
// slot scheduler; the encoding is also decoded by mode-control and telemetry.
package link_scheduler_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RX_WIN   = 3'd1,
    ST_G2TX     = 3'd2,
    ST_TX_WIN   = 3'd3,
    ST_TX_DRAIN = 3'd4,
    ST_G2RX     = 3'd5
  } state_e;

  // Window may straddle the frame wrap, so measure distance from offset modulo frame.
  function automatic logic in_window(input int unsigned slot, input int unsigned off,
                                     input int unsigned len, input int unsigned frame);
    int unsigned d;
    d = (slot + frame - off) % frame;
    return (len != 0) && (d < len);
  endfunction

endpackage

// File: rtl/link_scheduler_guard_timer.sv
// Loadable down-counter: done_o pulses exactly CYCLES-1 cycles after the load
// edge, so a state entered at that edge lasts CYCLES cycles.
module link_scheduler_guard_timer #(
  parameter int CYCLES = 480
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic done_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          armed_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= CW'(CYCLES - 1);
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) armed_q <= 1'b0;
      else             cnt_q   <= cnt_q - CW'(1);
    end
  end

  assign done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/link_scheduler.sv
// Half-duplex radio slot scheduler: alternates RX and TX windows within a slot
// frame, with a guard gap at every turnaround and a double-buffered TX config.
module link_scheduler
  import link_scheduler_pkg::*;
#(
  parameter int FRAME_SLOTS   = 16,
  parameter int SLOT_W        = 4,
  parameter int GUARD_CYCLES  = 480,
  parameter int TX_OFFSET_DEF = 8,
  parameter int TX_LEN_DEF    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               slot_tick_i,
  input  logic               enable_i,
  input  logic               cfg_valid_i,
  input  logic [SLOT_W-1:0]  cfg_offset_i,
  input  logic [SLOT_W-1:0]  cfg_len_i,
  output logic               cfg_ready_o,
  input  logic               rx_busy_i,
  input  logic               tx_busy_i,
  output logic               rx_en_o,
  output logic               tx_en_o,
  output logic [SLOT_W-1:0]  slot_idx_o,
  output logic [STATE_W-1:0] state_o,
  output logic               overrun_o
);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] act_off_q, act_len_q, shd_off_q, shd_len_q;
  logic              shd_full_q;
  state_e            state_q, state_d;
  logic              rx_en_q, tx_en_q, overrun_q, overrun_d, ovr_flag_q;
  logic              wrap, accept, in_win, guard_load, guard_done;

  assign wrap   = slot_tick_i && (slot_q == SLOT_W'(FRAME_SLOTS - 1));
  assign accept = cfg_valid_i && !shd_full_q;
  assign slot_d = !slot_tick_i ? slot_q : (wrap ? '0 : slot_q + SLOT_W'(1));
  assign in_win = in_window(32'(slot_q), 32'(act_off_q), 32'(act_len_q), FRAME_SLOTS);

  // Shadow is consumed at the wrap before a same-cycle offer can land, so a
  // config accepted on the wrap cycle waits for the next frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q     <= '0;
      act_off_q  <= SLOT_W'(TX_OFFSET_DEF);
      act_len_q  <= SLOT_W'(TX_LEN_DEF);
      shd_off_q  <= '0;
      shd_len_q  <= '0;
      shd_full_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      if (wrap && shd_full_q) begin
        act_off_q  <= shd_off_q;
        act_len_q  <= shd_len_q;
        shd_full_q <= 1'b0;
      end else if (accept) begin
        shd_off_q  <= SLOT_W'(32'(cfg_offset_i) % FRAME_SLOTS);
        shd_len_q  <= cfg_len_i;
        shd_full_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE:   if (enable_i) state_d = ST_G2RX;
      ST_RX_WIN: begin
        if (!enable_i)                   state_d = ST_IDLE;
        else if (in_win && !rx_busy_i)   state_d = ST_G2TX;
      end
      ST_G2TX: begin
        if (!enable_i) state_d = ST_IDLE;
        else if (guard_done) begin
          if (in_win) state_d = ST_TX_WIN;
          else begin
            state_d   = ST_RX_WIN;
            overrun_d = 1'b1;
          end
        end
      end
      ST_TX_WIN: begin
        if (!enable_i || !in_win)
          state_d = tx_busy_i ? ST_TX_DRAIN : (enable_i ? ST_G2RX : ST_IDLE);
      end
      ST_TX_DRAIN: begin
        if (slot_tick_i && !ovr_flag_q) overrun_d = 1'b1;
        if (!tx_busy_i) state_d = enable_i ? ST_G2RX : ST_IDLE;
      end
      ST_G2RX: begin
        if (!enable_i)       state_d = ST_IDLE;
        else if (guard_done) state_d = ST_RX_WIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign guard_load = ((state_d == ST_G2TX) || (state_d == ST_G2RX)) && (state_d != state_q);

  // Enables decode the next state so they change on the same edge as STATE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rx_en_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ovr_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_en_q    <= (state_d == ST_RX_WIN);
      tx_en_q    <= (state_d == ST_TX_WIN) || (state_d == ST_TX_DRAIN);
      overrun_q  <= overrun_d;
      ovr_flag_q <= (state_d == ST_TX_DRAIN) && (ovr_flag_q || overrun_d);
    end
  end

  link_scheduler_guard_timer #(
    .CYCLES (GUARD_CYCLES)
  ) u_guard (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (guard_load),
    .done_o (guard_done)
  );

  assign cfg_ready_o = ~shd_full_q;
  assign rx_en_o     = rx_en_q;
  assign tx_en_o     = tx_en_q;
  assign slot_idx_o  = slot_q;
  assign state_o     = state_q;
  assign overrun_o   = overrun_q;

endmodule
